// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file BIST initiator.
package regfile_bist_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  localparam logic [DATA_W-1:0] DEFAULT_SEED = 32'h0000_0001;
  localparam logic [DATA_W-1:0] DEFAULT_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_LAST,
    ST_DONE
  } state_e;

  // One in-flight read: compared against the regfile data one edge later.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
  } cmp_t;

endpackage

// File: rtl/regfile_bist_if.sv
// Port bundle between the BIST initiator (master) and the register file (slave).
interface regfile_bist_if;
  import regfile_bist_pkg::*;

  logic              ctrl_writeEn;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    output ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );

endinterface

// File: rtl/regfile_bist_lfsr.sv
// One step of a right-shifting Galois LFSR.
module regfile_bist_lfsr
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] next_c
);

  assign next_c = (cur >> 1) ^ (cur[0] ? POLY : '0);

endmodule

// File: rtl/regfile_bist.sv
// BIST initiator: writes an LFSR pattern (then its complement) to every register
// and reads it back on both ports, accumulating mismatches.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED  = DEFAULT_SEED,
  parameter logic [DATA_W-1:0] POLY  = DEFAULT_POLY,
  parameter int unsigned       ERR_W = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              start,
  regfile_bist_if.master    rf,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] first_fail_reg
);

  localparam int unsigned       SUM_W     = ERR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] wlfsr, wlfsr_nxt, rlfsr, rlfsr_nxt;
  logic [DATA_W-1:0] wlfsr_step_c, rlfsr_step_c, mask_c;
  logic              pass_idx, pass_idx_nxt;
  cmp_t              cmp, cmp_nxt;

  logic              we_nxt;
  logic [ADDR_W-1:0] wreg_nxt, rreg_nxt, ffr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              done_nxt, pass_nxt, fail_valid_nxt;
  logic [ERR_W-1:0]  err_nxt, err_cmp_c;
  logic [SUM_W-1:0]  err_sum_c;
  logic              mis_a_c, mis_b_c;

  regfile_bist_lfsr #(.POLY(POLY)) u_wlfsr (.cur(wlfsr), .next_c(wlfsr_step_c));
  regfile_bist_lfsr #(.POLY(POLY)) u_rlfsr (.cur(rlfsr), .next_c(rlfsr_step_c));

  // Compare the read issued last cycle; saturating error accumulation.
  always_comb begin
    mis_a_c   = cmp.valid && (rf.data_readRegA != cmp.exp_data);
    mis_b_c   = cmp.valid && (rf.data_readRegB != cmp.exp_data);
    err_sum_c = SUM_W'(err_count) + SUM_W'(mis_a_c) + SUM_W'(mis_b_c);
    err_cmp_c = err_sum_c[ERR_W] ? '1 : err_sum_c[ERR_W-1:0];
    mask_c    = {DATA_W{pass_idx}};
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    wlfsr_nxt      = wlfsr;
    rlfsr_nxt      = rlfsr;
    pass_idx_nxt   = pass_idx;
    cmp_nxt        = '0;
    we_nxt         = 1'b0;
    wreg_nxt       = '0;
    wdata_nxt      = '0;
    rreg_nxt       = '0;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_cmp_c;
    fail_valid_nxt = fail_valid | mis_a_c | mis_b_c;
    ffr_nxt        = (!fail_valid && (mis_a_c || mis_b_c)) ? cmp.addr : first_fail_reg;

    unique case (state)
      ST_IDLE: begin
        done_nxt = 1'b0;
        if (start) begin
          state_nxt      = ST_WRITE;
          err_nxt        = '0;
          fail_valid_nxt = 1'b0;
          ffr_nxt        = '0;
          pass_nxt       = 1'b0;
          pass_idx_nxt   = 1'b0;
          addr_nxt       = '0;
          wlfsr_nxt      = SEED;
        end
      end
      ST_WRITE: begin
        we_nxt    = 1'b1;
        wreg_nxt  = addr;
        wdata_nxt = wlfsr ^ mask_c;
        addr_nxt  = addr + ADDR_W'(1);
        wlfsr_nxt = wlfsr_step_c;
        if (addr == LAST_ADDR) begin
          state_nxt = ST_READ;
          addr_nxt  = '0;
          rlfsr_nxt = SEED;
        end
      end
      ST_READ: begin
        rreg_nxt         = addr;
        cmp_nxt.valid    = 1'b1;
        cmp_nxt.addr     = addr;
        // Register 0 is hardwired to zero in the regfile.
        cmp_nxt.exp_data = (addr == '0) ? '0 : (rlfsr ^ mask_c);
        addr_nxt         = addr + ADDR_W'(1);
        rlfsr_nxt        = rlfsr_step_c;
        if (addr == LAST_ADDR) state_nxt = ST_LAST;
      end
      ST_LAST: begin
        if (!pass_idx) begin
          state_nxt    = ST_WRITE;
          pass_idx_nxt = 1'b1;
          addr_nxt     = '0;
          wlfsr_nxt    = SEED;
        end else begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_cmp_c == '0);
        end
      end
      ST_DONE: begin
        done_nxt = 1'b1;
        if (!start) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state            <= ST_IDLE;
      addr             <= '0;
      wlfsr            <= SEED;
      rlfsr            <= SEED;
      pass_idx         <= 1'b0;
      cmp              <= '0;
      rf.ctrl_writeEn  <= 1'b0;
      rf.ctrl_writeReg <= '0;
      rf.data_writeReg <= '0;
      rf.ctrl_readRegA <= '0;
      rf.ctrl_readRegB <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      fail_valid       <= 1'b0;
      first_fail_reg   <= '0;
    end else begin
      state            <= state_nxt;
      addr             <= addr_nxt;
      wlfsr            <= wlfsr_nxt;
      rlfsr            <= rlfsr_nxt;
      pass_idx         <= pass_idx_nxt;
      cmp              <= cmp_nxt;
      rf.ctrl_writeEn  <= we_nxt;
      rf.ctrl_writeReg <= wreg_nxt;
      rf.data_writeReg <= wdata_nxt;
      rf.ctrl_readRegA <= rreg_nxt;
      rf.ctrl_readRegB <= rreg_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      err_count        <= err_nxt;
      fail_valid       <= fail_valid_nxt;
      first_fail_reg   <= ffr_nxt;
    end
  end

endmodule
